mips_io_bridge: RTL and testbench

//  Memory-mapped I/O stage downstream of the single-cycle MIPS datapath, beside DataMemory.

---
 rtl/mips_io_bridge_pkg.sv | 24 ++
 rtl/mips_io_bridge_uart_tx.sv | 103 ++++++++++
 rtl/mips_io_bridge.sv | 122 ++++++++++++
 tb/tb_mips_io_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_io_bridge_pkg.sv
// Shared definitions for the MIPS memory-mapped I/O bridge: register offsets,
// STATUS bit positions and UART transmitter state encodings.
package mips_io_bridge_pkg;

   localparam logic [3:0] OFS_PORT_OUT = 4'h0;
   localparam logic [3:0] OFS_PORT_IN  = 4'h4;
   localparam logic [3:0] OFS_TX_DATA  = 4'h8;
   localparam logic [3:0] OFS_STATUS   = 4'hC;

   localparam int unsigned STAT_FULL     = 0;
   localparam int unsigned STAT_EMPTY    = 1;
   localparam int unsigned STAT_BUSY     = 2;
   localparam int unsigned STAT_CHANGED  = 3;
   localparam int unsigned STAT_OVERFLOW = 4;
   localparam int unsigned STAT_W        = 5;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } txState_t;

endpackage

// File: rtl/mips_io_bridge_uart_tx.sv
// 8N1 UART transmitter: pops one byte from the TX FIFO when idle and shifts it
// out LSB first with a registered, glitch-free serial line.
module io_uart_tx
   import mips_io_bridge_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fifoEmpty,
   input  logic [7:0] fifoHead,
   output logic       pop_c,
   output logic       busy_c,
   output logic       uartTx
);

   localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

   txState_t           state, stateNext;
   logic [TIMER_W-1:0] timer, timerNext;
   logic [2:0]         bitIdx, bitIdxNext;
   logic [7:0]         shift, shiftNext;
   logic               txNext;
   logic               bitDone;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= TX_IDLE;
         timer  <= '0;
         bitIdx <= '0;
         shift  <= '0;
         uartTx <= 1'b1;
      end else begin
         state  <= stateNext;
         timer  <= timerNext;
         bitIdx <= bitIdxNext;
         shift  <= shiftNext;
         uartTx <= txNext;
      end
   end

   // txNext is the line level for the state being entered, so the line is registered
   always_comb begin
      stateNext  = state;
      timerNext  = timer;
      bitIdxNext = bitIdx;
      shiftNext  = shift;
      txNext     = uartTx;
      pop_c      = 1'b0;
      bitDone    = (timer == TIMER_LAST);
      case (state)
         TX_IDLE: begin
            txNext = 1'b1;
            if (!fifoEmpty) begin
               pop_c     = 1'b1;
               shiftNext = fifoHead;
               timerNext = '0;
               stateNext = TX_START;
               txNext    = 1'b0;
            end
         end
         TX_START: begin
            if (bitDone) begin
               timerNext  = '0;
               bitIdxNext = '0;
               stateNext  = TX_DATA;
               txNext     = shift[0];
            end else begin
               timerNext = timer + TIMER_W'(1);
            end
         end
         TX_DATA: begin
            if (bitDone) begin
               timerNext = '0;
               if (bitIdx == 3'd7) begin
                  stateNext = TX_STOP;
                  txNext    = 1'b1;
               end else begin
                  bitIdxNext = bitIdx + 3'd1;
                  shiftNext  = {1'b0, shift[7:1]};
                  txNext     = shift[1];
               end
            end else begin
               timerNext = timer + TIMER_W'(1);
            end
         end
         TX_STOP: begin
            if (bitDone) begin
               timerNext = '0;
               stateNext = TX_IDLE;
               txNext    = 1'b1;
            end else begin
               timerNext = timer + TIMER_W'(1);
            end
         end
         default: stateNext = TX_IDLE;
      endcase
   end

   assign busy_c = (state != TX_IDLE);

endmodule

// File: rtl/mips_io_bridge.sv
// Memory-mapped I/O beside DataMemory: output port, synchronized input port
// with change detect, and a byte FIFO feeding the UART transmitter.
module mips_io_bridge
   import mips_io_bridge_pkg::*;
#(
   parameter logic [31:0] IO_BASE      = 32'h1001_1000,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [7:0]  PortIn,
   output logic        io_select,
   output logic [31:0] io_read_data,
   output logic [31:0] PortOut,
   output logic        uart_tx
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [3:0]        offset;
   logic              hit, wrHit, rdHit;
   logic              portOutWe, push, portInRd, statusRd;
   logic [7:0]        syncStage1, syncStage2, inPrev;
   logic              changed, overflow;
   logic [7:0]        fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wrPtr, rdPtr;
   logic [CNT_W-1:0]  fifoCount;
   logic              fifoFull, fifoEmpty, pop, pushAccept, overflowSet, txBusy;
   logic [STAT_W-1:0] statusBits;

   // Word-aligned addresses inside the 16-byte window only
   assign offset    = Address[3:0];
   assign hit       = (Address[31:4] == IO_BASE[31:4]) && (Address[1:0] == 2'b00);
   assign io_select = hit;
   assign wrHit     = MemWrite && hit;
   assign rdHit     = MemRead && hit;
   assign portOutWe = wrHit && (offset == OFS_PORT_OUT);
   assign push      = wrHit && (offset == OFS_TX_DATA);
   assign portInRd  = rdHit && (offset == OFS_PORT_IN);
   assign statusRd  = rdHit && (offset == OFS_STATUS);

   assign fifoFull    = (fifoCount == CNT_W'(FIFO_DEPTH));
   assign fifoEmpty   = (fifoCount == '0);
   assign pushAccept  = push && (!fifoFull || pop);
   assign overflowSet = push && fifoFull && !pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PortOut    <= '0;
         syncStage1 <= '0;
         syncStage2 <= '0;
         inPrev     <= '0;
         changed    <= 1'b0;
         overflow   <= 1'b0;
         wrPtr      <= '0;
         rdPtr      <= '0;
         fifoCount  <= '0;
      end else begin
         if (portOutWe) PortOut <= WriteData;
         syncStage1 <= PortIn;
         syncStage2 <= syncStage1;
         inPrev     <= syncStage2;
         // A new event outranks a same-cycle clearing read
         if (syncStage2 != inPrev) changed <= 1'b1;
         else if (portInRd)        changed <= 1'b0;
         if (overflowSet)          overflow <= 1'b1;
         else if (statusRd)        overflow <= 1'b0;
         if (pushAccept) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)        rdPtr <= rdPtr + PTR_W'(1);
         case ({pushAccept, pop})
            2'b10:   fifoCount <= fifoCount + CNT_W'(1);
            2'b01:   fifoCount <= fifoCount - CNT_W'(1);
            default: fifoCount <= fifoCount;
         endcase
      end
   end

   // Storage is not reset; on a push at FULL the head is consumed before it is overwritten
   always_ff @(posedge clk) begin
      if (pushAccept) fifoMem[wrPtr] <= WriteData[7:0];
   end

   always_comb begin
      statusBits                = '0;
      statusBits[STAT_FULL]     = fifoFull;
      statusBits[STAT_EMPTY]    = fifoEmpty;
      statusBits[STAT_BUSY]     = txBusy;
      statusBits[STAT_CHANGED]  = changed;
      statusBits[STAT_OVERFLOW] = overflow;
   end

   always_comb begin
      io_read_data = '0;
      if (hit) begin
         case (offset)
            OFS_PORT_OUT: io_read_data = PortOut;
            OFS_PORT_IN:  io_read_data = {24'b0, syncStage2};
            OFS_STATUS:   io_read_data = {27'b0, statusBits};
            default:      io_read_data = '0;
         endcase
      end
   end

   io_uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uTx (
      .clk      (clk),
      .reset    (reset),
      .fifoEmpty(fifoEmpty),
      .fifoHead (fifoMem[rdPtr]),
      .pop_c    (pop),
      .busy_c   (txBusy),
      .uartTx   (uart_tx)
   );

endmodule

// File: tb/tb_mips_io_bridge.sv
// Directed self-checking bench for mips_io_bridge with a 4-clock UART bit time.
module tb_mips_io_bridge;

   localparam logic [31:0] BASE = 32'h1001_1000;
   localparam int unsigned CPB  = 4;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [7:0]  PortIn;
   logic        io_select;
   logic [31:0] io_read_data;
   logic [31:0] PortOut;
   logic        uart_tx;

   int assertCount = 0;
   int failCount   = 0;
   logic [8:0] rxQ[$];

   mips_io_bridge #(
      .IO_BASE(BASE),
      .FIFO_DEPTH(4),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .Address(Address),
      .WriteData(WriteData),
      .MemWrite(MemWrite),
      .MemRead(MemRead),
      .PortIn(PortIn),
      .io_select(io_select),
      .io_read_data(io_read_data),
      .PortOut(PortOut),
      .uart_tx(uart_tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Serial line decoder: samples mid-bit and queues {stop, data}
   initial begin
      logic [7:0] rxByte;
      forever begin
         @(posedge clk); #1;
         if (uart_tx === 1'b0) begin
            repeat (CPB / 2) @(posedge clk);
            #1;
            for (int b = 0; b < 8; b++) begin
               repeat (CPB) @(posedge clk);
               #1;
               rxByte[b] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            #1;
            rxQ.push_back({uart_tx, rxByte});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

   task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
      Address = a; WriteData = d; MemWrite = 1'b1;
      @(posedge clk); #1;
      MemWrite = 1'b0;
   endtask

   task automatic doRead(input logic [31:0] a, output logic [31:0] d);
      Address = a; MemRead = 1'b1;
      #1; d = io_read_data;
      @(posedge clk); #1;
      MemRead = 1'b0;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      Address = a; MemRead = 1'b0; MemWrite = 1'b0;
      #1; d = io_read_data;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      assertCount++; if (uart_tx !== 1'b1) begin failCount++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
      assertCount++; if (PortOut !== 32'h0) begin failCount++; $display("FAIL reset_portout: got %h expected 0", PortOut); end
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h2) begin failCount++; $display("FAIL reset_status: got %h expected 2", d); end
      reset = 1'b0;
      @(posedge clk); #1;
      doWrite(BASE, 32'h0000_00FF);
      doWrite(BASE + 32'h8, 32'h55);
      repeat (10) @(posedge clk);
      #1;
      // Mid-frame: data bit 1 of 0x55 is on the line
      assertCount++; if (uart_tx !== 1'b0) begin failCount++; $display("FAIL midframe_tx: got %b expected 0", uart_tx); end
      assertCount++; if (PortOut !== 32'hFF) begin failCount++; $display("FAIL midframe_portout: got %h expected ff", PortOut); end
      reset = 1'b1;
      #1;
      assertCount++; if (uart_tx !== 1'b1) begin failCount++; $display("FAIL midreset_tx: got %b expected 1", uart_tx); end
      assertCount++; if (PortOut !== 32'h0) begin failCount++; $display("FAIL midreset_portout: got %h expected 0", PortOut); end
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h2) begin failCount++; $display("FAIL midreset_status: got %h expected 2", d); end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      rxQ.delete();
   endtask

   task automatic test_port_out();
      logic [31:0] d;
      Address = BASE; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1;
      #1;
      assertCount++; if (io_select !== 1'b1) begin failCount++; $display("FAIL po_select: got %b expected 1", io_select); end
      assertCount++; if (PortOut !== 32'h0) begin failCount++; $display("FAIL po_before_edge: got %h expected 0", PortOut); end
      @(posedge clk); #1;
      MemWrite = 1'b0;
      assertCount++; if (PortOut !== 32'hDEAD_BEEF) begin failCount++; $display("FAIL po_after_edge: got %h expected deadbeef", PortOut); end
      doRead(BASE, d);
      assertCount++; if (d !== 32'hDEAD_BEEF) begin failCount++; $display("FAIL po_readback: got %h expected deadbeef", d); end
      Address = 32'h1001_0FFC; WriteData = 32'h1234_5678; MemWrite = 1'b1;
      #1;
      assertCount++; if (io_select !== 1'b0) begin failCount++; $display("FAIL below_window_select: got %b expected 0", io_select); end
      assertCount++; if (io_read_data !== 32'h0) begin failCount++; $display("FAIL below_window_rdata: got %h expected 0", io_read_data); end
      @(posedge clk); #1;
      MemWrite = 1'b0;
      assertCount++; if (PortOut !== 32'hDEAD_BEEF) begin failCount++; $display("FAIL below_window_portout: got %h expected deadbeef", PortOut); end
      Address = BASE + 32'h1;
      #1;
      assertCount++; if (io_select !== 1'b0) begin failCount++; $display("FAIL misaligned_select: got %b expected 0", io_select); end
      doWrite(BASE + 32'h4, 32'hFFFF_FFFF);
      peek(BASE + 32'h4, d);
      assertCount++; if (d !== 32'h0) begin failCount++; $display("FAIL ro_port_in: got %h expected 0", d); end
      assertCount++; if (PortOut !== 32'hDEAD_BEEF) begin failCount++; $display("FAIL ro_write_portout: got %h expected deadbeef", PortOut); end
      peek(BASE + 32'h8, d);
      assertCount++; if (d !== 32'h0) begin failCount++; $display("FAIL txdata_read: got %h expected 0", d); end
   endtask

   task automatic test_single_tx();
      logic [31:0] d;
      logic [9:0]  frame;
      logic        expBit;
      frame = 10'b1_0101_0101_0;  // stop, 0x55 MSB..LSB, start
      rxQ.delete();
      doWrite(BASE + 32'h8, 32'h55);
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h0) begin failCount++; $display("FAIL tx_status_queued: got %h expected 0", d); end
      assertCount++; if (uart_tx !== 1'b1) begin failCount++; $display("FAIL tx_idle_clk: got %b expected 1", uart_tx); end
      for (int j = 0; j < 10 * CPB; j++) begin
         @(posedge clk); #1;
         expBit = frame[j / CPB];
         assertCount++; if (uart_tx !== expBit) begin failCount++; $display("FAIL tx_line_clk%0d: got %b expected %b", j, uart_tx, expBit); end
         if (j == 0) begin
            peek(BASE + 32'hC, d);
            assertCount++; if (d !== 32'h6) begin failCount++; $display("FAIL tx_status_sending: got %h expected 6", d); end
         end
      end
      @(posedge clk); #1;
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h2) begin failCount++; $display("FAIL tx_status_done: got %h expected 2", d); end
      assertCount++; if (rxQ.size() !== 1 || rxQ[0] !== 9'h155) begin failCount++; $display("FAIL tx_rx_byte: got size %0d expected 1 byte 155", rxQ.size()); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [8:0]  expRx;
      rxQ.delete();
      for (int i = 1; i <= 5; i++) doWrite(BASE + 32'h8, 32'(i));
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h5) begin failCount++; $display("FAIL b2b_full: got %h expected 5", d); end
      doWrite(BASE + 32'h8, 32'h6);
      doRead(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h15) begin failCount++; $display("FAIL b2b_overflow: got %h expected 15", d); end
      doRead(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h5) begin failCount++; $display("FAIL b2b_overflow_cleared: got %h expected 5", d); end
      for (int i = 0; i < 500 && rxQ.size() < 5; i++) @(posedge clk);
      repeat (60) @(posedge clk);
      #1;
      assertCount++; if (rxQ.size() !== 5) begin failCount++; $display("FAIL b2b_count: got %0d expected 5", rxQ.size()); end
      for (int i = 0; i < 5; i++) begin
         expRx = {1'b1, 8'(i + 1)};
         assertCount++;
         if (i >= rxQ.size() || rxQ[i] !== expRx) begin failCount++; $display("FAIL b2b_byte%0d: got %h expected %h", i, (i < rxQ.size()) ? rxQ[i] : 9'h0, expRx); end
      end
   endtask

   task automatic test_port_in();
      logic [31:0] d;
      PortIn = 8'hA5;
      @(posedge clk); #1;
      peek(BASE + 32'h4, d);
      assertCount++; if (d !== 32'h0) begin failCount++; $display("FAIL pin_1clk: got %h expected 0", d); end
      @(posedge clk); #1;
      peek(BASE + 32'h4, d);
      assertCount++; if (d !== 32'hA5) begin failCount++; $display("FAIL pin_2clk: got %h expected a5", d); end
      @(posedge clk); #1;
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'hA) begin failCount++; $display("FAIL pin_changed: got %h expected a", d); end
      doRead(BASE + 32'h4, d);
      assertCount++; if (d !== 32'hA5) begin failCount++; $display("FAIL pin_read: got %h expected a5", d); end
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h2) begin failCount++; $display("FAIL pin_cleared: got %h expected 2", d); end
      PortIn = 8'h5A;
      repeat (2) @(posedge clk);
      #1;
      doRead(BASE + 32'h4, d);
      assertCount++; if (d !== 32'h5A) begin failCount++; $display("FAIL pin_read2: got %h expected 5a", d); end
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'hA) begin failCount++; $display("FAIL pin_set_wins: got %h expected a", d); end
      doRead(BASE + 32'h4, d);
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h2) begin failCount++; $display("FAIL pin_cleared2: got %h expected 2", d); end
   endtask

   task automatic test_push_at_pop();
      logic [31:0] d;
      logic [8:0]  expRx;
      rxQ.delete();
      for (int i = 0; i < 5; i++) doWrite(BASE + 32'h8, 32'(8'h11 + 8'(i)));
      // First frame started one clock after the first push; 37 more edges reach its end
      repeat (37) @(posedge clk);
      #1;
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h1) begin failCount++; $display("FAIL pap_idle_full: got %h expected 1", d); end
      doWrite(BASE + 32'h8, 32'h16);
      peek(BASE + 32'hC, d);
      assertCount++; if (d !== 32'h5) begin failCount++; $display("FAIL pap_accepted: got %h expected 5", d); end
      for (int i = 0; i < 600 && rxQ.size() < 6; i++) @(posedge clk);
      repeat (60) @(posedge clk);
      #1;
      assertCount++; if (rxQ.size() !== 6) begin failCount++; $display("FAIL pap_count: got %0d expected 6", rxQ.size()); end
      for (int i = 0; i < 6; i++) begin
         expRx = {1'b1, 8'h11 + 8'(i)};
         assertCount++;
         if (i >= rxQ.size() || rxQ[i] !== expRx) begin failCount++; $display("FAIL pap_byte%0d: got %h expected %h", i, (i < rxQ.size()) ? rxQ[i] : 9'h0, expRx); end
      end
   endtask

   initial begin
      reset = 1'b1; Address = '0; WriteData = '0;
      MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
      test_reset();
      test_port_out();
      test_single_tx();
      test_back_to_back();
      test_port_in();
      test_push_at_pop();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
